config_reporter: RTL and testbench

CONFIG_REPORTER -- requirements
Module: config_reporter

---
 rtl/config_reporter.sv | 121 ++++++++++++
 tb/tb_config_reporter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/config_reporter.sv
// Configuration reporter: snapshots seven temperature thresholds and a humidity limit,
// then streams them as a 10-frame report (header, data, XOR checksum) to a serial transmitter.
module config_reporter (
    input  logic       clock,
    input  logic       reset,
    input  logic       enviar_config,
    input  logic [7:0] temp1,
    input  logic [7:0] temp2,
    input  logic [7:0] temp3,
    input  logic [7:0] temp4,
    input  logic [7:0] temp5,
    input  logic [7:0] temp6,
    input  logic [7:0] temp7,
    input  logic [7:0] lim_um,
    input  logic       fim_tx,
    output logic       partida_tx,
    output logic [7:0] dado_tx,
    output logic       paridade_tx,
    output logic       ocupado,
    output logic       pronto_envio,
    output logic [3:0] db_estado
);

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        CAPTURA = 3'd1,
        ENVIA   = 3'd2,
        ESPERA  = 3'd3,
        FIM     = 3'd4
    } state_t;

    localparam logic [7:0] HEADER     = 8'hA5;
    localparam logic [3:0] LAST_FRAME = 4'd9;

    state_t          state_q, state_d;
    logic [3:0]      index_q, index_d;
    logic [7:0][7:0] snap_q, snap_d;
    logic [7:0]      checksum;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= INICIAL;
            index_q <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            snap_q  <= snap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        snap_d  = snap_q;
        case (state_q)
            INICIAL: begin
                if (enviar_config) state_d = CAPTURA;
            end
            CAPTURA: begin
                snap_d  = {lim_um, temp7, temp6, temp5, temp4, temp3, temp2, temp1};
                index_d = '0;
                state_d = ENVIA;
            end
            ENVIA: begin
                state_d = ESPERA;
            end
            ESPERA: begin
                if (fim_tx) begin
                    if (index_q < LAST_FRAME) begin
                        index_d = index_q + 4'd1;
                        state_d = ENVIA;
                    end else begin
                        state_d = FIM;
                    end
                end
            end
            FIM: begin
                // Park the index on the header so the idle payload is the header frame.
                index_d = '0;
                state_d = INICIAL;
            end
            default: begin
                index_d = '0;
                state_d = INICIAL;
            end
        endcase
    end

    always_comb begin
        checksum = '0;
        for (int i = 0; i < 8; i++) begin
            checksum = checksum ^ snap_q[i];
        end
    end

    // Out-of-range indices fall through to 0x00 rather than aliasing a real frame.
    always_comb begin
        dado_tx = 8'h00;
        case (index_q)
            4'd0:    dado_tx = HEADER;
            4'd1:    dado_tx = snap_q[0];
            4'd2:    dado_tx = snap_q[1];
            4'd3:    dado_tx = snap_q[2];
            4'd4:    dado_tx = snap_q[3];
            4'd5:    dado_tx = snap_q[4];
            4'd6:    dado_tx = snap_q[5];
            4'd7:    dado_tx = snap_q[6];
            4'd8:    dado_tx = snap_q[7];
            4'd9:    dado_tx = checksum;
            default: dado_tx = 8'h00;
        endcase
    end

    assign paridade_tx  = ^dado_tx;
    assign partida_tx   = (state_q == ENVIA);
    assign pronto_envio = (state_q == FIM);
    assign ocupado      = (state_q != INICIAL);
    assign db_estado    = {1'b0, state_q};

endmodule

// File: tb/tb_config_reporter.sv
// Directed bench for config_reporter: table of report vectors with hand-computed checksums,
// plus hand-written sequences for reset, stall, ignored request and back-to-back reports.
module tb_config_reporter;

    typedef struct {
        logic [6:0][7:0] temps;
        logic [7:0]      limUm;
        logic [7:0]      expChecksum;
        int              fimDelay;
        int              chgFrame;
        int              reqFrame;
        int              stallFrame;
        bit              backToBack;
        bit              fimNoise;
    } reportVec_t;

    localparam int NV = 6;

    logic       clock;
    logic       reset;
    logic       enviar_config;
    logic [7:0] temp1, temp2, temp3, temp4, temp5, temp6, temp7, lim_um;
    logic       fim_tx;
    logic       partida_tx;
    logic [7:0] dado_tx;
    logic       paridade_tx;
    logic       ocupado;
    logic       pronto_envio;
    logic [3:0] db_estado;

    int nChecks = 0;
    int nFails  = 0;
    reportVec_t vecs [NV];

    config_reporter dut (
        .clock        (clock),
        .reset        (reset),
        .enviar_config(enviar_config),
        .temp1        (temp1),
        .temp2        (temp2),
        .temp3        (temp3),
        .temp4        (temp4),
        .temp5        (temp5),
        .temp6        (temp6),
        .temp7        (temp7),
        .lim_um       (lim_um),
        .fim_tx       (fim_tx),
        .partida_tx   (partida_tx),
        .dado_tx      (dado_tx),
        .paridade_tx  (paridade_tx),
        .ocupado      (ocupado),
        .pronto_envio (pronto_envio),
        .db_estado    (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic reportVec_t makeVec(
        input logic [7:0] t1, input logic [7:0] t2, input logic [7:0] t3, input logic [7:0] t4,
        input logic [7:0] t5, input logic [7:0] t6, input logic [7:0] t7, input logic [7:0] lim,
        input logic [7:0] cks, input int delay, input int chg, input int req, input int stall,
        input bit b2b, input bit noise);
        reportVec_t v;
        v.temps       = {t7, t6, t5, t4, t3, t2, t1};
        v.limUm       = lim;
        v.expChecksum = cks;
        v.fimDelay    = delay;
        v.chgFrame    = chg;
        v.reqFrame    = req;
        v.stallFrame  = stall;
        v.backToBack  = b2b;
        v.fimNoise    = noise;
        return v;
    endfunction

    // Expected frame content comes from the table entry, never from the live inputs.
    function automatic logic [7:0] expFrame(input reportVec_t v, input int f);
        logic [7:0] b;
        case (f)
            0:       b = 8'hA5;
            8:       b = v.limUm;
            9:       b = v.expChecksum;
            default: b = v.temps[f-1];
        endcase
        return b;
    endfunction

    task automatic applyStimulus(input reportVec_t v);
        temp1  = v.temps[0];
        temp2  = v.temps[1];
        temp3  = v.temps[2];
        temp4  = v.temps[3];
        temp5  = v.temps[4];
        temp6  = v.temps[5];
        temp7  = v.temps[6];
        lim_um = v.limUm;
    endtask

    // Starts in INICIAL (or in FIM for back-to-back) and returns during the FIM cycle.
    task automatic runReport(input reportVec_t v);
        logic [7:0] exp;
        bit stallOk;
        applyStimulus(v);
        enviar_config = 1'b1;
        if (v.backToBack) begin
            tick();
            checkOutput("b2bFimIgnoresRequest", db_estado, 0);
        end
        fim_tx = v.fimNoise;
        tick();
        enviar_config = 1'b0;
        checkOutput("capturaState", db_estado, 1);
        checkOutput("capturaOcupado", ocupado, 1);
        checkOutput("capturaNoStart", partida_tx, 0);
        tick();
        for (int f = 0; f < 10; f++) begin
            exp = expFrame(v, f);
            checkOutput("startPulse", partida_tx, 1);
            checkOutput("enviaState", db_estado, 2);
            checkOutput("frameData", dado_tx, exp);
            checkOutput("frameParity", paridade_tx, ^exp);
            checkOutput("enviaNoPronto", pronto_envio, 0);
            tick();
            fim_tx = 1'b0;
            if (f == v.stallFrame) begin
                stallOk = 1'b1;
                for (int c = 0; c < 1000; c++) begin
                    if (db_estado !== 4'd3 || dado_tx !== exp || partida_tx !== 1'b0 || pronto_envio !== 1'b0)
                        stallOk = 1'b0;
                    tick();
                end
                checkOutput("stallHold", stallOk, 1);
            end
            if (f == v.chgFrame) temp3 = 8'hFF;
            if (f == v.reqFrame) begin
                enviar_config = 1'b1;
                tick();
                enviar_config = 1'b0;
                checkOutput("ignoredRequest", db_estado, 3);
            end
            for (int d = 1; d < v.fimDelay; d++) begin
                checkOutput("esperaState", db_estado, 3);
                checkOutput("esperaStable", dado_tx, exp);
                checkOutput("esperaNoStart", partida_tx, 0);
                tick();
            end
            checkOutput("esperaBeforeFim", db_estado, 3);
            fim_tx = 1'b1;
            tick();
            fim_tx = v.fimNoise;
        end
        checkOutput("fimState", db_estado, 4);
        checkOutput("fimPronto", pronto_envio, 1);
        checkOutput("fimNoStart", partida_tx, 0);
        checkOutput("fimOcupado", ocupado, 1);
        fim_tx = 1'b0;
    endtask

    task automatic finishIdle();
        tick();
        checkOutput("idleState", db_estado, 0);
        checkOutput("idleOcupado", ocupado, 0);
        checkOutput("idlePronto", pronto_envio, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("idleNoQueued", db_estado, 0);
            checkOutput("idleNoStart", partida_tx, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        enviar_config = 1'b0;
        fim_tx = 1'b0;
        temp1 = 8'h00; temp2 = 8'h00; temp3 = 8'h00; temp4 = 8'h00;
        temp5 = 8'h00; temp6 = 8'h00; temp7 = 8'h00; lim_um = 8'h00;

        vecs[0] = makeVec(8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h50, 8'h47, 5, -1, -1, -1, 1'b0, 1'b0);
        vecs[1] = makeVec(8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h50, 8'h47, 5,  1,  4, -1, 1'b0, 1'b0);
        vecs[2] = makeVec(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, -1, -1,  7, 1'b0, 1'b0);
        vecs[3] = makeVec(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 1, -1, -1, -1, 1'b0, 1'b0);
        vecs[4] = makeVec(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h81, 8'hFE, 2, -1, -1, -1, 1'b1, 1'b0);
        vecs[5] = makeVec(8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h12, 8'h34, 8'hD9, 3, -1, -1, -1, 1'b0, 1'b1);

        enviar_config = 1'b1;
        fim_tx = 1'b1;
        tick();
        tick();
        checkOutput("resetState", db_estado, 0);
        checkOutput("resetOcupado", ocupado, 0);
        checkOutput("resetPartida", partida_tx, 0);
        checkOutput("resetPronto", pronto_envio, 0);
        checkOutput("resetData", dado_tx, 8'hA5);
        checkOutput("resetParity", paridade_tx, 0);
        reset = 1'b0;
        enviar_config = 1'b0;
        fim_tx = 1'b0;
        tick();
        checkOutput("postResetIdle", db_estado, 0);

        for (int i = 0; i < NV; i++) begin
            runReport(vecs[i]);
            if (!(i + 1 < NV && vecs[i+1].backToBack)) finishIdle();
        end

        // Abort a report in the ESPERA of frame 6 and confirm late fim_tx is ignored.
        applyStimulus(vecs[0]);
        enviar_config = 1'b1;
        tick();
        enviar_config = 1'b0;
        tick();
        for (int f = 0; f < 6; f++) begin
            tick();
            fim_tx = 1'b1;
            tick();
            fim_tx = 1'b0;
        end
        tick();
        checkOutput("midFrame6Espera", db_estado, 3);
        checkOutput("midFrame6Data", dado_tx, 8'h15);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midResetState", db_estado, 0);
        checkOutput("midResetOcupado", ocupado, 0);
        checkOutput("midResetData", dado_tx, 8'hA5);
        fim_tx = 1'b1;
        tick();
        fim_tx = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput("midResetNoStart", partida_tx, 0);
            checkOutput("midResetNoPronto", pronto_envio, 0);
            checkOutput("midResetIdle", db_estado, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
